// File: rtl/mlp_pkg.sv
// Shared widths, FSM state type and fixed weights for the 7-3-10 ReLU classifier.
package mlp_pkg;

    localparam int ACC_W = 14;
    localparam int H_W   = 9;
    localparam int W_W   = 8;
    localparam int N_IN  = 7;
    localparam int N_HID = 3;
    localparam int N_OUT = 10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HID,
        S_OUT,
        S_DONE
    } state_t;

    // Hidden weights are held at H_W so the hidden pass is plain H_W signed arithmetic.
    localparam logic signed [H_W-1:0] W1 [N_HID][N_IN] = '{
        '{-9'sd3,  -9'sd5,  9'sd0,   9'sd4,  -9'sd1,  9'sd0,   -9'sd2},
        '{ 9'sd28,  9'sd19, -9'sd24, 9'sd15,  9'sd37, -9'sd37,  9'sd29},
        '{ 9'sd23,  9'sd36,  9'sd32, -9'sd9,  9'sd3,  -9'sd28, -9'sd30}
    };

    localparam logic signed [H_W-1:0] B1 [N_HID] = '{9'sd0, 9'sd5, 9'sd9};

    localparam logic signed [W_W-1:0] W2 [N_OUT][N_HID] = '{
        '{-8'sd6,  -8'sd1,   8'sd23},
        '{ 8'sd5,  -8'sd38,  8'sd32},
        '{ 8'sd5,   8'sd36, -8'sd30},
        '{ 8'sd3,   8'sd17,  8'sd8},
        '{-8'sd3,  -8'sd27,  8'sd20},
        '{-8'sd4,   8'sd23, -8'sd29},
        '{ 8'sd3,   8'sd36, -8'sd48},
        '{-8'sd1,  -8'sd17,  8'sd31},
        '{-8'sd6,   8'sd28, -8'sd13},
        '{-8'sd1,   8'sd7,   8'sd4}
    };

    localparam logic signed [ACC_W-1:0] B2 [N_OUT] = '{
        -14'sd180, -14'sd120, -14'sd280, -14'sd350, 14'sd380,
         14'sd360, -14'sd30,  -14'sd340, -14'sd90,  14'sd350
    };

    function automatic logic signed [ACC_W-1:0] sext_h(input logic signed [H_W-1:0] v);
        return ACC_W'(v);
    endfunction

endpackage

// File: rtl/mlp_infer_seq_if.sv
// Feature-in / class-out handshake bundle for the sequenced classifier.
interface mlp_infer_seq_if;
    import mlp_pkg::*;

    logic                    in_valid;
    logic                    in_ready;
    logic [N_IN-1:0]         in_bits;
    logic                    out_valid;
    logic                    out_ready;
    logic [3:0]              out_class;
    logic signed [ACC_W-1:0] out_score;
    logic                    busy;

    modport master (
        output in_valid, in_bits, out_ready,
        input  in_ready, out_valid, out_class, out_score, busy
    );

    modport slave (
        input  in_valid, in_bits, out_ready,
        output in_ready, out_valid, out_class, out_score, busy
    );

endinterface

// File: rtl/mlp_mac.sv
// Signed accumulator shared by every neuron: load a bias or add one term per edge.
// Latency: sum is combinational (acc + term); acc updates on the edge.
// Backpressure: none, the controller strobes load/add only when it wants an update.
module mlp_mac
    import mlp_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic                    add,
    input  logic signed [ACC_W-1:0] bias,
    input  logic signed [ACC_W-1:0] term,
    output logic signed [ACC_W-1:0] sum
);

    logic signed [ACC_W-1:0] acc_q;

    assign sum = acc_q + term;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (load) begin
            acc_q <= bias;
        end else if (add) begin
            acc_q <= sum;
        end
    end

endmodule

// File: rtl/mlp_infer_seq.sv
// Sequenced 7-3-10 ReLU classifier: one shared MAC walks all neurons, running argmax over logits.
// Latency: out_valid 51 edges after accept; one vector per 53 cycles with out_ready high.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
module mlp_infer_seq
    import mlp_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    mlp_infer_seq_if.slave io
);

    state_t                  state_q, state_d;
    logic [N_IN-1:0]         x_q;
    logic [3:0]              row_q;
    logic [2:0]              col_q;
    logic signed [H_W-1:0]   h_q [N_HID];
    logic signed [ACC_W-1:0] best_score_q, best_score_d;
    logic [3:0]              best_class_q, best_class_d;
    logic signed [ACC_W-1:0] out_score_q;
    logic [3:0]              out_class_q;

    logic                    mac_load, mac_add;
    logic signed [ACC_W-1:0] mac_bias, mac_term, mac_sum;
    logic signed [ACC_W-1:0] hid_term, out_term;
    logic signed [H_W-1:0]   relu_h;
    logic                    hid_last, out_last, hid_last_row, out_last_row, take_new;

    mlp_mac u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (mac_load),
        .add   (mac_add),
        .bias  (mac_bias),
        .term  (mac_term),
        .sum   (mac_sum)
    );

    assign hid_last     = (col_q == 3'(N_IN - 1));
    assign out_last     = (col_q == 3'(N_HID - 1));
    assign hid_last_row = (row_q == 4'(N_HID - 1));
    assign out_last_row = (row_q == 4'(N_OUT - 1));

    assign hid_term = x_q[col_q] ? sext_h(W1[row_q[1:0]][col_q]) : '0;
    // Only the low ACC_W product bits are kept; the logits are bounded well inside ACC_W.
    assign out_term = ACC_W'(W2[row_q][col_q[1:0]]) * ACC_W'(h_q[col_q[1:0]]);
    assign relu_h   = mac_sum[H_W-1] ? '0 : mac_sum[H_W-1:0];

    // First logit always loads; later ones need a strict win so ties keep the lower class.
    assign take_new     = (row_q == 4'd0) || (mac_sum > best_score_q);
    assign best_score_d = take_new ? mac_sum : best_score_q;
    assign best_class_d = take_new ? row_q : best_class_q;

    assign io.in_ready  = (state_q == S_IDLE);
    assign io.busy      = (state_q != S_IDLE);
    assign io.out_valid = (state_q == S_DONE);
    assign io.out_class = out_class_q;
    assign io.out_score = out_score_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mac_load = 1'b0;
        mac_add  = 1'b0;
        mac_bias = '0;
        mac_term = '0;
        case (state_q)
            S_IDLE: begin
                if (io.in_valid) begin
                    state_d  = S_HID;
                    mac_load = 1'b1;
                    mac_bias = sext_h(B1[0]);
                end
            end
            S_HID: begin
                mac_term = hid_term;
                if (hid_last) begin
                    mac_load = 1'b1;
                    if (hid_last_row) begin
                        state_d  = S_OUT;
                        mac_bias = B2[0];
                    end else begin
                        mac_bias = sext_h(B1[row_q[1:0] + 2'd1]);
                    end
                end else begin
                    mac_add = 1'b1;
                end
            end
            S_OUT: begin
                mac_term = out_term;
                if (out_last) begin
                    if (out_last_row) begin
                        state_d = S_DONE;
                    end else begin
                        mac_load = 1'b1;
                        mac_bias = B2[row_q + 4'd1];
                    end
                end else begin
                    mac_add = 1'b1;
                end
            end
            S_DONE: begin
                if (io.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q          <= '0;
            row_q        <= '0;
            col_q        <= '0;
            best_score_q <= '0;
            best_class_q <= '0;
            out_score_q  <= '0;
            out_class_q  <= '0;
            for (int m = 0; m < N_HID; m++) begin
                h_q[m] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (io.in_valid) begin
                        x_q   <= io.in_bits;
                        row_q <= '0;
                        col_q <= '0;
                    end
                end
                S_HID: begin
                    if (hid_last) begin
                        h_q[row_q[1:0]] <= relu_h;
                        col_q           <= '0;
                        row_q           <= hid_last_row ? 4'd0 : row_q + 4'd1;
                    end else begin
                        col_q <= col_q + 3'd1;
                    end
                end
                S_OUT: begin
                    if (out_last) begin
                        best_score_q <= best_score_d;
                        best_class_q <= best_class_d;
                        col_q        <= '0;
                        if (out_last_row) begin
                            row_q       <= '0;
                            out_score_q <= best_score_d;
                            out_class_q <= best_class_d;
                        end else begin
                            row_q <= row_q + 4'd1;
                        end
                    end else begin
                        col_q <= col_q + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mlp_infer_seq.sv
// Scoreboard bench for mlp_infer_seq: driver pushes hand-computed results, negedge monitor checks.
module tb_mlp_infer_seq;

    localparam int LAT = 51;

    typedef struct {
        int cls;
        int score;
        int acc_edge;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_cmp;
    int   n_bad;
    bit   inflight;
    exp_t sb [$];

    mlp_infer_seq_if io ();

    mlp_infer_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input longint act, input longint exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Monitor: derives every expected handshake/status value from the scoreboard head.
    always @(negedge clk) begin
        if (rst_n) begin
            inflight = (sb.size() != 0) && (cyc >= sb[0].acc_edge);
            chk("in_ready", io.in_ready, !inflight);
            chk("busy", io.busy, inflight);
            chk("out_valid", io.out_valid, inflight && (cyc >= sb[0].acc_edge + LAT));
            if (inflight && io.out_valid) begin
                chk("out_class", io.out_class, sb[0].cls);
                chk("out_score", $signed(io.out_score), sb[0].score);
                if (io.out_ready) begin
                    void'(sb.pop_front());
                end
            end
        end
    end

    // Must be called just after a rising edge; returns the absolute accept edge.
    task automatic send(input logic [6:0] bits, input int cls, input int score, output int acc);
        acc = -1;
        io.in_valid = 1'b1;
        io.in_bits  = bits;
        for (int w = 0; w < 300; w++) begin
            @(negedge clk);
            if (io.in_ready) break;
        end
        chk("accept_ready", io.in_ready, 1);
        if (io.in_ready) begin
            acc = cyc + 1;
            sb.push_back('{cls, score, acc});
            @(posedge clk);
            #1;
        end
        io.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int w = 0; w < 400 && sb.size() != 0; w++) @(negedge clk);
        chk("drain_empty", sb.size(), 0);
        if (sb.size() != 0) sb.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1, a2;
        cyc          = 0;
        n_cmp        = 0;
        n_bad        = 0;
        rst_n        = 1'b0;
        io.in_valid  = 1'b0;
        io.in_bits   = '0;
        io.out_ready = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_out_valid", io.out_valid, 0);
        chk("rst_out_class", io.out_class, 0);
        chk("rst_out_score", $signed(io.out_score), 0);
        chk("rst_busy", io.busy, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", io.in_ready, 1);
        @(posedge clk);
        #1;

        // Single vectors with hand-computed argmax results.
        send(7'h00, 4, 425, a0);
        drain();
        send(7'h10, 5, 978, a0);
        drain();

        // Input bus churns while busy; it must be ignored.
        send(7'h7F, 8, 1458, a0);
        for (int w = 0; w < 200; w++) begin
            @(posedge clk);
            #1 io.in_bits = 7'($urandom);
            if (sb.size() == 0) break;
        end
        drain();

        // Output stall with a pending request behind it.
        io.out_ready = 1'b0;
        fork
            begin
                send(7'h10, 5, 978, a0);
                send(7'h00, 4, 425, a1);
            end
            begin
                for (int w = 0; w < 300 && !io.out_valid; w++) @(negedge clk);
                repeat (20) @(negedge clk);
                @(posedge clk);
                #1 io.out_ready = 1'b1;
            end
        join
        drain();
        chk("pending_accept_edge", a1 - a0, 74);

        // Reset at E30 aborts the inference and clears outputs.
        send(7'h7F, 8, 1458, a0);
        while (cyc < a0 + 29) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("mid_rst_out_valid", io.out_valid, 0);
        chk("mid_rst_out_class", io.out_class, 0);
        chk("mid_rst_out_score", $signed(io.out_score), 0);
        chk("mid_rst_busy", io.busy, 0);
        chk("mid_rst_in_ready", io.in_ready, 1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        send(7'h00, 4, 425, a0);
        drain();

        // Back-to-back with in_valid and out_ready held high.
        send(7'h00, 4, 425, a0);
        send(7'h10, 5, 978, a1);
        send(7'h7F, 8, 1458, a2);
        drain();
        chk("b2b_spacing_01", a1 - a0, 53);
        chk("b2b_spacing_12", a2 - a1, 53);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
